// File: rtl/tpu_matmul_ctrl_if.sv
// Handshake and memory-write bus between the matmul sequencer and its host, memories and systolic array.
// master = host/environment side, slave = tpu_matmul_ctrl.
interface tpu_matmul_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              start;
    logic              abort;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we_w;
    logic              mem_we_a;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              sa_start;
    logic              sa_en;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, in_valid, in_data, res_valid, res_data,
        input  in_ready, mem_we_w, mem_we_a, mem_addr, mem_wdata,
               sa_start, sa_en, res_ready, busy, done, err
    );

    modport slave (
        input  start, abort, in_valid, in_data, res_valid, res_data,
        output in_ready, mem_we_w, mem_we_a, mem_addr, mem_wdata,
               sa_start, sa_en, res_ready, busy, done, err
    );
endinterface

// File: rtl/tpu_matmul_ctrl.sv
// Sequencer for one DIMxDIM matmul: loads weights/features, runs the systolic array, writes results back.
// Optional macro TPU_CTRL_PERF_EN adds the perf_cyc busy-cycle counter output.
module tpu_matmul_ctrl #(
    parameter int DIM     = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = $clog2(2*DIM*DIM),
    parameter int RUN_CYC = 3*DIM-2
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef TPU_CTRL_PERF_EN
    output logic [15:0]        perf_cyc,
`endif
    tpu_matmul_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_A = 3'd2,
        RUN    = 3'd3,
        WB     = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(DIM*DIM-1);
    localparam logic [ADDR_W-1:0] RUN_LAST  = ADDR_W'(RUN_CYC-1);
    localparam logic [ADDR_W-1:0] WB_BASE   = ADDR_W'(DIM*DIM);

    function automatic logic is_load(input state_t s);
        return (s == LOAD_W) || (s == LOAD_A);
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_next_s;

    logic              in_ready_r;
    logic              mem_we_w_r;
    logic              mem_we_a_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              sa_start_r;
    logic              sa_en_r;
    logic              res_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic              we_w_next_s;
    logic              we_a_next_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic [DATA_W-1:0] wdata_next_s;

    logic              in_acc_s;
    logic              res_acc_s;
    logic              start_acc_s;
    logic              err_set_s;

    // Handshakes qualify against the registered ready flags the outside world sees.
    always_comb begin
        in_acc_s    = bus.in_valid & in_ready_r;
        res_acc_s   = bus.res_valid & res_ready_r;
        start_acc_s = (state_r == IDLE) & bus.start & ~bus.abort;
        err_set_s   = ~bus.abort &
                      (((state_r != IDLE) & bus.start) | ((state_r == RUN) & bus.res_valid));
    end

    // Next-state, counter and next write-port values.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        we_w_next_s  = 1'b0;
        we_a_next_s  = 1'b0;
        addr_next_s  = mem_addr_r;
        wdata_next_s = mem_wdata_r;
        if (bus.abort) begin
            next_state_s = IDLE;
            cnt_next_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        next_state_s = LOAD_W;
                        cnt_next_s   = '0;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                LOAD_W, LOAD_A: begin
                    if (in_acc_s) begin
                        we_w_next_s  = (state_r == LOAD_W);
                        we_a_next_s  = (state_r == LOAD_A);
                        addr_next_s  = cnt_r;
                        wdata_next_s = bus.in_data;
                        if (cnt_r == LAST_ELEM) begin
                            next_state_s = (state_r == LOAD_W) ? LOAD_A : RUN;
                            cnt_next_s   = '0;
                        end else begin
                            cnt_next_s = cnt_r + ADDR_W'(1);
                        end
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                RUN: begin
                    // Results arriving here are dropped; err_set_s flags them.
                    if (cnt_r == RUN_LAST) begin
                        next_state_s = WB;
                        cnt_next_s   = '0;
                    end else begin
                        cnt_next_s = cnt_r + ADDR_W'(1);
                    end
                end
                WB: begin
                    if (res_acc_s) begin
                        we_a_next_s  = 1'b1;
                        addr_next_s  = WB_BASE + cnt_r;
                        wdata_next_s = bus.res_data;
                        if (cnt_r == LAST_ELEM) begin
                            next_state_s = DONE;
                            cnt_next_s   = '0;
                        end else begin
                            cnt_next_s = cnt_r + ADDR_W'(1);
                        end
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                DONE: begin
                    next_state_s = IDLE;
                    cnt_next_s   = '0;
                end
                default: begin
                    next_state_s = IDLE;
                    cnt_next_s   = '0;
                end
            endcase
        end
    end

    // State, counter and all registered outputs; flags are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            in_ready_r  <= 1'b0;
            mem_we_w_r  <= 1'b0;
            mem_we_a_r  <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            sa_start_r  <= 1'b0;
            sa_en_r     <= 1'b0;
            res_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= cnt_next_s;
            in_ready_r  <= is_load(next_state_s);
            mem_we_w_r  <= we_w_next_s;
            mem_we_a_r  <= we_a_next_s;
            mem_addr_r  <= addr_next_s;
            mem_wdata_r <= wdata_next_s;
            sa_start_r  <= (next_state_s == RUN) && (state_r != RUN);
            sa_en_r     <= (next_state_s == RUN);
            res_ready_r <= (next_state_s == WB);
            busy_r      <= (next_state_s != IDLE);
            done_r      <= (next_state_s == DONE);
        end
    end

    // Sticky protocol error; only an accepted start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (start_acc_s) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

`ifdef TPU_CTRL_PERF_EN
    logic [15:0] perf_cyc_r;

    // Busy-cycle counter, saturating; holds after done until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cyc_r <= 16'h0000;
        end else if (start_acc_s) begin
            perf_cyc_r <= 16'h0000;
        end else if ((state_r != IDLE) && (perf_cyc_r != 16'hFFFF)) begin
            perf_cyc_r <= perf_cyc_r + 16'h0001;
        end else begin
            perf_cyc_r <= perf_cyc_r;
        end
    end

    assign perf_cyc = perf_cyc_r;
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.mem_we_w  = mem_we_w_r;
    assign bus.mem_we_a  = mem_we_a_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.sa_start  = sa_start_r;
    assign bus.sa_en     = sa_en_r;
    assign bus.res_ready = res_ready_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_tpu_matmul_ctrl.sv
// Directed self-checking bench for tpu_matmul_ctrl at DIM=4 with a memory/array model.
module tb_tpu_matmul_ctrl;
    localparam int DIM    = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tpu_matmul_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
`ifdef TPU_CTRL_PERF_EN
    logic [15:0] perf_cyc;
`endif

    tpu_matmul_ctrl #(.DIM(DIM), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef TPU_CTRL_PERF_EN
        .perf_cyc (perf_cyc),
`endif
        .bus      (bus)
    );

    logic [7:0] wm [16] = '{8'd4, 8'd0, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd0,
                            8'd4, 8'd3, 8'd0, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1};
    logic [7:0] am [16] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4,
                            8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4};
    int         exp_row [4] = '{40, 27, 14, 8};
    logic [7:0] cm [16];

    // memory / event monitor
    logic [7:0] wmem [32];
    logic [7:0] fmem [32];
    int wwr [32] = '{default: 0};
    int fwr [32] = '{default: 0};
    int nw = 0, na = 0, nst = 0, nen = 0, ndone = 0, nboth = 0, cyc = 0;
    int a_last_cyc = -1, sa_start_cyc = -2;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_we_w) begin
            wmem[bus.mem_addr] <= bus.mem_wdata;
            wwr[bus.mem_addr]  <= wwr[bus.mem_addr] + 1;
            nw <= nw + 1;
        end
        if (bus.mem_we_a) begin
            fmem[bus.mem_addr] <= bus.mem_wdata;
            fwr[bus.mem_addr]  <= fwr[bus.mem_addr] + 1;
            na <= na + 1;
            if (bus.mem_addr == 5'd15) a_last_cyc <= cyc;
        end
        if (bus.mem_we_w && bus.mem_we_a) nboth <= nboth + 1;
        if (bus.sa_start) begin
            nst <= nst + 1;
            sa_start_cyc <= cyc;
        end
        if (bus.sa_en) nen <= nen + 1;
        if (bus.done)  ndone <= ndone + 1;
    end

    int n_chk = 0, n_fail = 0;
    int s_nw, s_na, s_nst, s_nen, s_ndone;
    int s_wwr [32];
    int s_fwr [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, bus.in_ready, bus.mem_we_w, bus.mem_we_a, bus.mem_addr, bus.mem_wdata,
                bus.sa_start, bus.sa_en, bus.res_ready, bus.busy, bus.done, bus.err};
    endfunction

    task automatic snap();
        s_nw = nw; s_na = na; s_nst = nst; s_nen = nen; s_ndone = ndone;
        s_wwr = wwr; s_fwr = fwr;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic feed_inputs(input bit gap, input int start_at);
        int  idx = 0;
        int  guard = 0;
        bit  acc;
        while (idx < 32 && guard < 300) begin
            bus.in_valid = !(gap && (guard % 2 == 1));
            bus.in_data  = (idx < 16) ? wm[idx] : am[idx-16];
            bus.start    = (idx == start_at);
            acc = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check("in_stream_complete", idx, 32);
    endtask

    task automatic feed_results(input bit gap, input int abort_at);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (!bus.res_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("res_ready_rise", bus.res_ready, 1);
        guard = 0;
        while (idx < 16 && guard < 300) begin
            if (idx == abort_at) begin
                bus.res_valid = 1'b0;
                bus.abort     = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                break;
            end
            bus.res_valid = !(gap && (guard % 2 == 1));
            bus.res_data  = cm[idx];
            acc = bus.res_valid && bus.res_ready;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        bus.res_valid = 1'b0;
    endtask

    task automatic wait_done(input bit start_in_done);
        int g = 0;
        while (!bus.done && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", bus.done, 1);
        bus.start = start_in_done;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_done", bus.busy, 0);
        check("done_one_cycle", bus.done, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic job_checks(input string tag);
        int bad_img = 0;
        int bad_wr  = 0;
        for (int i = 0; i < 16; i++) begin
            if (wmem[i] !== wm[i]) bad_img++;
            if (fmem[i] !== am[i]) bad_img++;
            if (fmem[16+i] !== 8'(exp_row[i%4])) bad_img++;
            if (wwr[i] - s_wwr[i] != 1) bad_wr++;
            if (wwr[16+i] - s_wwr[16+i] != 0) bad_wr++;
        end
        for (int i = 0; i < 32; i++) begin
            if (fwr[i] - s_fwr[i] != 1) bad_wr++;
        end
        check({tag, "_we_w_count"}, nw - s_nw, 16);
        check({tag, "_we_a_count"}, na - s_na, 32);
        check({tag, "_sa_start_count"}, nst - s_nst, 1);
        check({tag, "_sa_en_cycles"}, nen - s_nen, 10);
        check({tag, "_done_count"}, ndone - s_ndone, 1);
        check({tag, "_both_strobes"}, nboth, 0);
        check({tag, "_image_errors"}, bad_img, 0);
        check({tag, "_per_word_writes"}, bad_wr, 0);
    endtask

    initial begin
        int sum;
        int bad;
        bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.res_valid = 1'b0; bus.res_data = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                sum = 0;
                for (int k = 0; k < 4; k++) sum += int'(am[i*4+k]) * int'(wm[k*4+j]);
                cm[i*4+j] = 8'(sum);
            end
        end

        // reset state
        #12;
        check("reset_outputs", outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_outputs", outs(), 0);

        // nominal back-to-back job
        snap();
        do_start();
        check("busy_in_load_w", bus.busy, 1);
        check("in_ready_in_load_w", bus.in_ready, 1);
        feed_inputs(1'b0, -1);
        check("sa_en_after_load", bus.sa_en, 1);
        check("in_ready_low_in_run", bus.in_ready, 0);
        feed_results(1'b0, -1);
        wait_done(1'b0);
        job_checks("nominal");
        check("nominal_err", bus.err, 0);
        check("sa_start_with_last_a", sa_start_cyc, a_last_cyc);
        check("word16", fmem[16], 40);
        check("word31", fmem[31], 8);
`ifdef TPU_CTRL_PERF_EN
        check("perf_cyc_nominal", perf_cyc, 59);
`endif

        // gappy input and result streams
        snap();
        do_start();
        feed_inputs(1'b1, -1);
        feed_results(1'b1, -1);
        wait_done(1'b0);
        job_checks("gappy");
        check("gappy_err", bus.err, 0);

        // start during LOAD_A and during DONE
        snap();
        do_start();
        feed_inputs(1'b0, 20);
        check("err_start_in_load_a", bus.err, 1);
        feed_results(1'b0, -1);
        wait_done(1'b1);
        job_checks("start_in_load");
        check("err_sticky", bus.err, 1);
        check("no_restart_from_done", bus.busy, 0);
        do_start();
        check("err_cleared_by_start", bus.err, 0);
        check("busy_new_job", bus.busy, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_load_w_busy", bus.busy, 0);
        check("abort_load_w_ready", bus.in_ready, 0);

        // abort at WB result 5
        @(negedge clk);
        snap();
        do_start();
        feed_inputs(1'b0, -1);
        feed_results(1'b0, 5);
        check("abort_wb_busy", bus.busy, 0);
        check("abort_wb_res_ready", bus.res_ready, 0);
        check("abort_wb_we_a", bus.mem_we_a, 0);
        repeat (3) @(negedge clk);
        check("abort_wb_no_done", ndone - s_ndone, 0);
        bad = 0;
        for (int i = 16; i < 32; i++) begin
            if (fwr[i] - s_fwr[i] != ((i < 21) ? 1 : 0)) bad++;
        end
        check("abort_wb_partial_writes", bad, 0);
        check("abort_wb_word20", fmem[20], 40);
        snap();
        do_start();
        feed_inputs(1'b0, -1);
        feed_results(1'b0, -1);
        wait_done(1'b0);
        job_checks("after_abort");

        // result during RUN, then reset mid-RUN
        do_start();
        feed_inputs(1'b0, -1);
        bus.res_valid = 1'b1;
        @(negedge clk);
        bus.res_valid = 1'b0;
        check("err_res_in_run", bus.err, 1);
        check("sa_en_before_reset", bus.sa_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", outs(), 0);

        // start and abort together in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy", bus.busy, 0);
        @(negedge clk);
        check("start_abort_ready", bus.in_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
